real_table_reader: RTL and testbench
====================================

REAL_TABLE_READER -- requirements
Module: real_table_reader

Interface
REQ-001 SHALL have parameter DEPTH_REAL, real, 4.0: table depth, converted at elaboration to DEPTH = $rtoi(DEPTH_REAL).
REQ-002 SHALL have parameter MAX_LEN_REAL, real, 8.5: maximum burst length, converted to MAX_LEN = $rtoi(MAX_LEN_REAL), i.e. truncated to 8.
REQ-003 SHALL have parameter WIDTH, integer, 8: entry width in bits.
REQ-004 SHALL derive localparams AW = max(1, $clog2(DEPTH)) and LW = $clog2(MAX_LEN+1), both integer-only at elaboration.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  table write strobe.
REQ-008 wr_addr  input  AW  table write address.
REQ-009 wr_data  input  WIDTH  table write data.
REQ-010 start  input  1  burst request pulse.
REQ-011 start_addr  input  AW  first address of burst.
REQ-012 start_len  input  LW  requested entry count.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 rd_valid  output  1  rd_data/rd_addr hold a valid entry.
REQ-015 rd_ready  input  1  downstream accepts entry when rd_valid && rd_ready.
REQ-016 rd_data  output  WIDTH  entry value.
REQ-017 rd_addr  output  AW  entry address.
REQ-018 done  output  1  one-cycle pulse after last entry is accepted.

Function
REQ-019 SHALL hold a DEPTH x WIDTH table; on reset entry j SHALL be loaded with (j*2) mod 2^WIDTH.
REQ-020 SHALL write wr_data to wr_addr on any cycle with wr_en, in every state; wr_addr >= DEPTH SHALL be ignored.
REQ-021 FSM states: IDLE, FETCH, PRESENT, DONE.
REQ-022 IDLE: start accepted only here; start with start_len == 0 SHALL go to DONE directly, otherwise to FETCH with addr = start_addr, remaining = min(start_len, MAX_LEN).
REQ-023 start_addr >= DEPTH SHALL be reduced modulo DEPTH on acceptance.
REQ-024 FETCH: registered table read of addr, one cycle, then PRESENT; first rd_valid SHALL occur 2 cycles after the start-accept edge.
REQ-025 PRESENT: rd_valid high; rd_data and rd_addr SHALL stay stable until a handshake.
REQ-026 On handshake: remaining decrements; if it reaches 0, go to DONE; else addr advances and FETCH repeats (sustained rate one entry per 2 cycles).
REQ-027 Address wrap: addr == DEPTH-1 SHALL advance to 0.
REQ-028 DONE: done high for exactly one cycle, then IDLE; busy low in IDLE only.
REQ-029 start while not IDLE SHALL be ignored (no queueing).
REQ-030 Write to the address being fetched in the same cycle: FETCH SHALL return the pre-write value (read-before-write); later fetches SHALL see the new value.
REQ-031 A write to an already presented entry SHALL NOT alter rd_data.

Reset
REQ-032 rst SHALL override all activity, including mid-burst: state IDLE, busy/rd_valid/done 0, rd_data/rd_addr 0, internal counters 0, table reloaded per REQ-019.
REQ-033 wr_en and start asserted together with rst SHALL be ignored.

Structure
REQ-034 The state encoding localparams and the real-to-integer helpers for DEPTH/MAX_LEN SHALL live in shared package real_table_pkg.
REQ-035 Storage SHALL be a sub-module real_table_mem (write port, registered read port, reset-pattern load), built with a generate loop over DEPTH entries.

Verification
REQ-036 DEPTH_REAL=4.0: after reset, start addr 0 len 4, rd_ready=1 -> rd_data 0,2,4,6 at rd_addr 0..3, done one cycle after last handshake.
REQ-037 start addr 3 len 3 -> rd_addr 3,0,1 with data 6,0,2 (wrap).
REQ-038 start len 15 with MAX_LEN_REAL=8.5 -> exactly 8 entries, addresses 0,1,2,3,0,1,2,3.
REQ-039 rd_ready held low 5 cycles in PRESENT -> rd_valid, rd_data, rd_addr stable; second start during this time ignored.
REQ-040 write 0xAA to addr 1 in the same cycle FETCH reads addr 1 -> presents 2; next burst over addr 1 presents 0xAA.
REQ-041 rst asserted mid-burst -> next cycle busy=0, rd_valid=0, done=0; a new burst from addr 1 returns 2 (table reloaded).

Source files
------------

// File: rtl/real_table_pkg.sv
// Shared definitions for the real-parameterised table reader: FSM state
// encoding and elaboration-time helpers that turn real parameters into
// integer sizes.
package real_table_pkg;

  // Reader FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Truncating real -> integer conversion used for DEPTH and MAX_LEN
  function automatic int real_to_int(input real r);
    return $rtoi(r);
  endfunction

  // Address width for a table of d entries; never narrower than one bit
  function automatic int addr_width(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

  // Length-counter width able to hold the value m
  function automatic int len_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/real_table_mem.sv
// Table storage: one write port, one registered read port, and a reset
// that reloads every entry with the pattern (index*2).
module real_table_mem
  import real_table_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][WIDTH-1:0] entries;

  // One register per entry. An address outside 0..DEPTH-1 matches no
  // entry, so such writes fall on the floor without extra logic.
  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_entry
      localparam logic [WIDTH-1:0] INIT = WIDTH'(j * 2);

      // Entry j: reset pattern load, otherwise write on address match
      always_ff @(posedge clk) begin
        if (rst)
          entries[j] <= INIT;
        else if (wr_en && (wr_addr == AW'(j)))
          entries[j] <= wr_data;
      end
    end
  endgenerate

  // Registered read. It samples the array before this edge's write lands,
  // which gives read-before-write on a same-cycle collision. Outside a
  // read the output holds, so later writes never disturb a presented entry.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= entries[rd_addr];
  end

endmodule

// File: rtl/real_table_reader.sv
// Burst reader over a small register table. A start in IDLE launches a burst
// of up to MAX_LEN entries from start_addr, wrapping at the table end. Each
// entry takes one fetch cycle plus a ready/valid presentation cycle.
module real_table_reader
  import real_table_pkg::*;
#(
  parameter real DEPTH_REAL   = 4.0,
  parameter real MAX_LEN_REAL = 8.5,
  parameter int  WIDTH        = 8,
  localparam int DEPTH        = real_to_int(DEPTH_REAL),
  localparam int MAX_LEN      = real_to_int(MAX_LEN_REAL),
  localparam int AW           = addr_width(DEPTH),
  localparam int LW           = len_width(MAX_LEN)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [LW-1:0]    start_len,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    rd_addr,
  output logic             done
);

  localparam logic [LW-1:0] LEN_CAP   = LW'(MAX_LEN);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [LW-1:0]   remain, remain_nxt;
  logic [AW-1:0]   start_addr_mod;
  logic            fetch;

  // Fold an out-of-range start address back into the table. Done in 32 bits
  // so a power-of-two DEPTH never turns into a zero divisor at width AW.
  always_comb begin
    start_addr_mod = AW'(32'(start_addr) % 32'(DEPTH));
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    remain_nxt = remain;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (start_len == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt  = ST_FETCH;
            addr_nxt   = start_addr_mod;
            remain_nxt = (start_len > LEN_CAP) ? LEN_CAP : start_len;
          end
        end
      end
      ST_FETCH: begin
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (rd_ready) begin
          remain_nxt = remain - 1'b1;
          if (remain == LW'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_FETCH;
            addr_nxt  = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, burst address and remaining-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      remain <= remain_nxt;
    end
  end

  // Presented address is captured alongside the table read so it stays
  // paired with rd_data for the whole presentation
  always_ff @(posedge clk) begin
    if (rst)
      rd_addr <= '0;
    else if (fetch)
      rd_addr <= addr;
  end

  // Status outputs are pure state decodes
  always_comb begin
    fetch    = (state == ST_FETCH);
    busy     = (state != ST_IDLE);
    rd_valid = (state == ST_PRESENT);
    done     = (state == ST_DONE);
  end

  real_table_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (fetch),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_real_table_reader.sv
// Scoreboard bench for real_table_reader with default parameters
// (DEPTH 4, MAX_LEN 8, WIDTH 8).
module tb_real_table_reader;

  localparam int DEPTH = 4;
  localparam int MAXL  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] start_addr;
  logic [3:0] start_len;
  logic       busy;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [1:0] rd_addr;
  logic       done;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tbl[DEPTH];
  int         n_chk  = 0;
  int         n_fail = 0;

  real_table_reader dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tbl_reset();
    for (int j = 0; j < DEPTH; j++) tbl[j] = 8'((j * 2) & 8'hFF);
  endtask

  // Runs one burst. stall>0 holds rd_ready low for that many cycles on the
  // first entry (with a stray start and a write to the presented entry);
  // wr_fetch writes 0xAA to the burst address on the edge that fetches it.
  task automatic run_burst(input int a, input int len, input int stall, input bit wr_fetch);
    int  n, ad, cyc, first, hs;
    bit  seen, prev_hs, stalled;
    exp_t e;
    n  = (len > MAXL) ? MAXL : len;
    ad = a % DEPTH;
    for (int i = 0; i < n; i++) begin
      e.addr = ad;
      e.data = int'(tbl[ad]);
      exp_q.push_back(e);
      ad = (ad + 1) % DEPTH;
    end
    rd_ready   = (stall == 0);
    start      = 1'b1;
    start_addr = 2'(a);
    start_len  = 4'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (wr_fetch) begin
      wr_en   = 1'b1;
      wr_addr = 2'(a);
      wr_data = 8'hAA;
      tbl[a % DEPTH] = 8'hAA;
    end
    cyc = 0; first = -1; hs = 0; seen = 0; prev_hs = 0; stalled = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wr_fetch && cyc == 2) wr_en = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("done_after_last_hs", 32'(prev_hs), 32'(n > 0));
      end
      if (rd_valid && first < 0) first = cyc;
      if (rd_valid && stall > 0 && !stalled && exp_q.size() > 0) begin
        stalled = 1'b1;
        for (int k = 0; k < stall; k++) begin
          chk("stall_valid", 32'(rd_valid), 32'd1);
          chk("stall_addr", 32'(rd_addr), 32'(exp_q[0].addr));
          chk("stall_data", 32'(rd_data), 32'(exp_q[0].data));
          if (k == 1) begin start = 1'b1; start_addr = 2'd0; start_len = 4'd1; end
          if (k == 2) start = 1'b0;
          if (k == 3) begin
            wr_en = 1'b1; wr_addr = 2'(exp_q[0].addr); wr_data = 8'h55;
            tbl[exp_q[0].addr] = 8'h55;
          end
          if (k == 4) wr_en = 1'b0;
          @(negedge clk);
          cyc++;
        end
        start    = 1'b0;
        wr_en    = 1'b0;
        rd_ready = 1'b1;
      end
      prev_hs = rd_valid && rd_ready;
      if (prev_hs) begin
        hs++;
        if (exp_q.size() == 0) begin
          chk("extra_entry", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", 32'(rd_addr), 32'(e.addr));
          chk("rd_data", 32'(rd_data), 32'(e.data));
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (n > 0) chk("first_valid_latency", 32'(first), 32'd2);
    chk("entry_count", 32'(hs), 32'(n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; start_len = '0; rd_ready = 1'b1;
    tbl_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(0, 4, 0, 0);   // 0,2,4,6
    run_burst(3, 3, 0, 0);   // wrap: 6,0,2
    run_burst(0, 15, 0, 0);  // capped at 8 entries
    run_burst(2, 2, 5, 0);   // stall, stray start, write to presented entry
    run_burst(2, 1, 0, 0);   // sees 0x55 written during the stall
    run_burst(1, 1, 0, 1);   // read-before-write: presents 2
    run_burst(1, 1, 0, 0);   // now 0xAA
    run_burst(0, 0, 0, 0);   // zero length goes straight to done

    // Reset in the middle of a burst, with write and start held alongside
    rd_ready = 1'b1; start = 1'b1; start_addr = 2'd0; start_len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
    start = 1'b1; start_addr = 2'd1; start_len = 4'd2;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    tbl_reset();
    @(negedge clk);
    chk("postrst_busy", 32'(busy), 32'd0);
    run_burst(1, 1, 0, 0);   // table reloaded: 2

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
